// File: rtl/sar_search_controller_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_controller_pkg;

    localparam int unsigned SAR_N     = 4;
    localparam int unsigned SAR_IDX_W = $clog2(SAR_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TEST  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Exactly one of great/less/equal: odd parity, but not all three.
    function automatic logic flags_valid(input logic great, input logic less, input logic equal);
        return (great ^ less ^ equal) && !(great && less && equal);
    endfunction

endpackage

// File: rtl/sar_search_controller.sv
// Drives trial values into a magnitude comparator and recovers its hidden operand MSB first,
// with a start/busy/done handshake and detection of inconsistent comparator answers.
module sar_search_controller
    import sar_search_controller_pkg::*;
#(
    parameter int N = SAR_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] trial,
    input  logic         cmp_great,
    input  logic         cmp_less,
    input  logic         cmp_equal,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         found,
    output logic         err
);

    localparam int IDX_W = $clog2(N);

    state_e             state_q, state_d;
    logic [N-1:0]       trial_q, trial_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_m1;
    logic [N-1:0]       result_q, result_d;
    logic               found_q, found_d;
    logic               err_q, err_d;
    logic               flags_ok;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            idx_q    <= IDX_W'(N - 1);
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign flags_ok = flags_valid(cmp_great, cmp_less, cmp_equal);
    assign idx_m1   = idx_q - IDX_W'(1);

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                trial_d = '0;
                if (start) begin
                    trial_d[N-1] = 1'b1;
                    idx_d        = IDX_W'(N - 1);
                    found_d      = 1'b0;
                    err_d        = 1'b0;
                    state_d      = TEST;
                end
            end

            TEST: begin
                if (!flags_ok) begin
                    result_d = trial_q;
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    trial_d  = '0;
                    state_d  = DONE;
                end else if (cmp_equal) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    trial_d  = '0;
                    state_d  = DONE;
                end else begin
                    // Trial overshot the target: this bit must be zero.
                    if (cmp_great) begin
                        trial_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        trial_d[idx_m1] = 1'b1;
                        idx_d           = idx_m1;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                result_d = trial_q;
                if (flags_ok && cmp_equal) begin
                    found_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                trial_d = '0;
                state_d = DONE;
            end

            DONE: begin
                trial_d = '0;
                idx_d   = IDX_W'(N - 1);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                trial_d = '0;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = (state_q == TEST) || (state_q == CHECK);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Self-checking bench: behavioural comparator as target holder, scoreboard of expected outcomes.
module tb_sar_search_controller;

    localparam int N      = 4;
    localparam int BUDGET = 3 * N + 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] trial;
    logic         cmp_great, cmp_less, cmp_equal;
    logic         busy, done;
    logic [N-1:0] result;
    logic         found, err;

    logic [N-1:0] target;
    logic         fault_force;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] result;
        logic         found;
        logic         err;
        int           cycle;
    } exp_t;

    exp_t sb_q[$];

    sar_search_controller #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .trial     (trial),
        .cmp_great (cmp_great),
        .cmp_less  (cmp_less),
        .cmp_equal (cmp_equal),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .found     (found),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Comparator golden model; fault_force presents an illegal great&less answer.
    always_comb begin
        cmp_great = (trial > target);
        cmp_less  = (trial < target);
        cmp_equal = (trial == target);
        if (fault_force) begin
            cmp_great = 1'b1;
            cmp_less  = 1'b1;
            cmp_equal = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Healthy search: equality is first seen when the trial reaches the lowest set bit.
    function automatic int exp_done_cycle(input logic [N-1:0] tgt);
        for (int b = 0; b < N; b++) begin
            if (tgt[b]) return N - b + 1;
        end
        return N + 2;
    endfunction

    // Trial at TEST cycle j on a healthy comparator: target bits above idx, plus bit idx set.
    function automatic logic [N-1:0] exp_trial(input logic [N-1:0] tgt, input int j);
        int           idx;
        logic [N-1:0] hi_mask;
        idx     = N - j;
        hi_mask = ~((N'(1) << (idx + 1)) - N'(1));
        if (idx == N - 1) hi_mask = '0;
        return (tgt & hi_mask) | (N'(1) << idx);
    endfunction

    task automatic run_search(input logic [N-1:0] tgt, input int fault_cyc,
                              input logic [N-1:0] er, input logic ef, input logic ee,
                              input int ecyc, input bit hold_start);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   got;
        e.result = er;
        e.found  = ef;
        e.err    = ee;
        e.cycle  = ecyc;
        sb_q.push_back(e);

        target = tgt;
        start  = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        cyc         = 1;
        fault_force = (fault_cyc == 1);
        got         = 1'b0;
        while (!got && cyc <= BUDGET) begin
            if (done) begin
                got   = 1'b1;
                got_e = sb_q.pop_front();
                check("done_cycle", cyc, got_e.cycle);
                check("result", result, got_e.result);
                check("found", found, got_e.found);
                check("err", err, got_e.err);
                check("trial_in_done", trial, 0);
                check("busy_in_done", busy, 0);
            end else begin
                if (busy !== 1'b1) check("busy_during_search", busy, 1);
                if (fault_cyc == 0 && cyc <= N && trial !== exp_trial(tgt, cyc))
                    check("trial_seq", trial, exp_trial(tgt, cyc));
                step();
                cyc++;
                fault_force = (cyc == fault_cyc);
            end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_front());
        end
        fault_force = 1'b0;
        step();
        start = 1'b0;
        check("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        target      = '0;
        fault_force = 1'b0;
        step();
        step();
        check("rst_trial", trial, 0);
        check("rst_outputs", {busy, done, found, err}, 4'b0000);
        check("rst_result", result, 0);
        rst = 1'b0;
        step();

        // Main search patterns and boundaries.
        run_search(4'd11, 0, 4'd11, 1'b1, 1'b0, 5, 1'b0);
        check("model_cycle_11", exp_done_cycle(4'd11), 5);
        run_search(4'd0, 0, 4'd0, 1'b1, 1'b0, 6, 1'b0);
        run_search(4'd8, 0, 4'd8, 1'b1, 1'b0, 2, 1'b0);
        run_search(4'd15, 0, 4'd15, 1'b1, 1'b0, 5, 1'b0);

        // Illegal great&less on the second TEST trial (12 when target > 8).
        run_search(4'd13, 2, 4'd12, 1'b0, 1'b1, 3, 1'b0);
        // Illegal answer on the CHECK cycle.
        run_search(4'd0, 5, 4'd0, 1'b0, 1'b1, 6, 1'b0);
        // found/err cleared again by the next accepted start.
        run_search(4'd6, 0, 4'd6, 1'b1, 1'b0, exp_done_cycle(4'd6), 1'b0);

        // Reset during TEST cycle 2 aborts without a done pulse.
        begin
            int dones;
            target = 4'd11;
            start  = 1'b1;
            step();
            start = 1'b0;
            step();
            check("pre_rst_busy", busy, 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("abort_trial", trial, 0);
            check("abort_result", result, 0);
            check("abort_flags", {busy, done, found, err}, 4'b0000);
            dones = 0;
            for (int i = 0; i < N + 4; i++) begin
                step();
                if (done) dones++;
            end
            check("abort_no_done", dones, 0);
        end

        // start held through busy and DONE: one search, one done.
        run_search(4'd5, 0, 4'd5, 1'b1, 1'b0, exp_done_cycle(4'd5), 1'b1);
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < N + 4; i++) begin
                step();
                if (done) dones++;
            end
            check("held_start_single_done", dones, 0);
        end

        // Back-to-back sweep of every target.
        for (int t = 0; t < (1 << N); t++) begin
            run_search(N'(t), 0, N'(t), 1'b1, 1'b0, exp_done_cycle(N'(t)), 1'b0);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Successive-approximation search engine that sits on the far side of the team's N-bit magnitude comparator.
- It drives the comparator's x operand with trial values and consumes the great/less/equal flags to recover the unknown operand y, MSB first.
- It is used for threshold discovery and self-test of the comparator datapath.
- It owns the start/busy/done handshake and flags inconsistent comparator answers.

Parameters:
- N, 4, operand width; even, >= 2; must match the attached comparator's N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a search; sampled only in IDLE
- trial  output  N  value driven to comparator x input (registered)
- cmp_great  input  1  comparator: trial > target
- cmp_less  input  1  comparator: trial < target
- cmp_equal  input  1  comparator: trial == target
- busy  output  1  high in TEST and CHECK
- done  output  1  one-cycle pulse, DONE state
- result  output  N  recovered target; valid from done, held until next accepted start
- found  output  1  result confirmed equal by comparator; held with result
- err  output  1  comparator answer inconsistent; held with result

Behaviour:
- Clock and reset: single clock domain clk; rst is synchronous, active-high.
- Reset values: state=IDLE, trial=0, result=0, found=0, err=0, busy=0, done=0, bit index=N-1. A reset mid-search aborts immediately with no done pulse.
- Comparator interface: combinational. Flags are sampled on the same edge that trial was presented for. Exactly one flag must be high; any other pattern is invalid.
- IDLE:
  - trial=0.
  - On start: trial<=1<<(N-1), idx<=N-1, clear found/err, go TEST.
  - start in any other state is ignored; no queuing.
- TEST (bit idx under test, trial bit idx=1):
  - Invalid flags: err<=1, found<=0, result<=trial, go DONE.
  - cmp_equal: result<=trial, found<=1, go DONE (early exit).
  - cmp_great: clear trial bit idx. cmp_less: keep it.
  - If idx>0: set trial bit idx-1, idx<=idx-1, stay TEST. If idx==0: go CHECK.
- CHECK: trial holds the final candidate.
  - cmp_equal only: result<=trial, found<=1.
  - Otherwise: result<=trial, err<=1.
  - Go DONE.
- DONE: done=1 for exactly one cycle, trial=0, then IDLE. start in DONE is ignored.
- Latency, with start sampled at edge 0:
  - TEST occupies cycles 1..N, CHECK is cycle N+1, done is high in cycle N+2 (worst case).
  - Equal at TEST cycle k gives done in cycle k+1.
  - Minimum: target=2^(N-1) gives done in cycle 2.
- Widths: all trial arithmetic is bitwise set/clear on N bits; no carries, no wrap-around.
- Target range: every target 0..2^N-1 is reachable. Target 0 always needs CHECK, because no TEST trial is zero.
- found/err: never both 1; at most one is set per search.

Decomposition:
- Shared package holds:
  - state enum {IDLE, TEST, CHECK, DONE}
  - flag-validity function (exactly one of great/less/equal)
  - localparam for index width clog2(N)
- No sub-module is natural; a single FSM plus trial/index/result registers. The bench instantiates the existing comparator as the golden target holder.

Test Plan:
- N=4, target 11, start: trials 8(less), 12(great), 10(less), 11(equal) -> done cycle 5, result=11, found=1, err=0.
- Target 0: trials 8,4,2,1 all great, CHECK trial 0 equal -> done cycle 6, result=0, found=1.
- Target 8: first trial equal -> done cycle 2, result=8, found=1. Target 15: 8,12,14 less, 15 equal -> done cycle 5.
- Faulty comparator model forcing great&less high on 2nd TEST -> err=1, found=0, done next cycle, result=12.
- rst asserted in TEST cycle 2 -> next cycle all outputs 0, IDLE, no done. start held through busy -> ignored; exactly one done per accepted start.
- Sweep all 16 targets back-to-back, start re-asserted the cycle after done -> every result matches, found=1.
